// File: rtl/tpfifo_inf.sv
// Synchronous FIFO over an inferred two-port RAM (one write port, one registered read port).
// Occupancy is tracked in its own counter; status flags are registered from the next-state level.
module tpfifo_inf #(
   parameter int DW        = 32,
   parameter int AW        = 7,
   parameter int AF_THRESH = 120
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          flush,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   output logic          full,
   output logic          almost_full,
   input  logic          rd_en,
   output logic [DW-1:0] q,
   output logic          q_valid,
   output logic          empty,
   output logic [AW:0]   level,
   output logic          overflow,
   output logic          underflow,
   input  logic          clr_err
);

   localparam int          DEPTH   = 2 ** AW;
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_L    = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] ONE_L   = (AW+1)'(1);

   logic [DW-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   level_q, level_d;
   logic          full_q, empty_q, af_q;
   logic [DW-1:0] q_q;
   logic          q_valid_q;
   logic          ovf_q, ovf_d, unf_q, unf_d;
   logic          wr_acc, rd_acc;

   // Acceptance uses the pre-edge flags, so a same-cycle read never frees room for a write.
   assign wr_acc = wr_en && !full_q  && !flush && !reset;
   assign rd_acc = rd_en && !empty_q && !flush && !reset;

   always_comb begin
      level_d = level_q;
      if (wr_acc && !rd_acc) begin
         level_d = level_q + ONE_L;
      end else if (rd_acc && !wr_acc) begin
         level_d = level_q - ONE_L;
      end
      ovf_d = (ovf_q && !clr_err) || (wr_en && full_q  && !flush);
      unf_d = (unf_q && !clr_err) || (rd_en && empty_q && !flush);
   end

   always_ff @(posedge clock) begin
      if (wr_acc) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q_q <= '0;
      end else if (rd_acc) begin
         q_q <= mem[rd_ptr_q];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         af_q      <= 1'b0;
         q_valid_q <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
         if (flush) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            af_q      <= 1'b0;
            q_valid_q <= 1'b0;
         end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q   <= level_d;
            full_q    <= (level_d == DEPTH_L);
            empty_q   <= (level_d == '0);
            af_q      <= (level_d >= AF_L);
            q_valid_q <= rd_acc;
         end
      end
   end

   assign full        = full_q;
   assign empty       = empty_q;
   assign almost_full = af_q;
   assign level       = level_q;
   assign q           = q_q;
   assign q_valid     = q_valid_q;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;

endmodule

// File: tb/tb_tpfifo_inf.sv
// Directed and randomized bench for tpfifo_inf against a queue-based reference model.
module tb_tpfifo_inf;

   localparam int DW    = 32;
   localparam int AW    = 7;
   localparam int AF    = 120;
   localparam int DEPTH = 2 ** AW;

   logic          clock = 1'b0;
   logic          reset, flush, wr_en, rd_en, clr_err;
   logic [DW-1:0] wr_data;
   logic          full, almost_full, q_valid, empty, overflow, underflow;
   logic [DW-1:0] q;
   logic [AW:0]   level;

   int vectors = 0;
   int miscompares = 0;

   logic [DW-1:0] mq [$];
   logic [DW-1:0] m_q;
   logic          m_qv, m_ovf, m_unf;

   tpfifo_inf #(.DW(DW), .AW(AW), .AF_THRESH(AF)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
      .rd_en(rd_en), .q(q), .q_valid(q_valid), .empty(empty), .level(level),
      .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      int n;
      n = mq.size();
      chk("level", DW'(level), DW'(n));
      chk("empty", DW'(empty), DW'(n == 0));
      chk("full", DW'(full), DW'(n == DEPTH));
      chk("almost_full", DW'(almost_full), DW'(n >= AF));
      chk("q_valid", DW'(q_valid), DW'(m_qv));
      chk("q", q, m_q);
      chk("overflow", DW'(overflow), DW'(m_ovf));
      chk("underflow", DW'(underflow), DW'(m_unf));
   endtask

   // One clock: drive inputs, advance the model by the FIFO rules, compare after the edge.
   task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic fl, input logic ce);
      int  n;
      bit  wa, ra;
      wr_en = w; wr_data = d; rd_en = r; flush = fl; clr_err = ce;
      n  = mq.size();
      wa = w && (n < DEPTH) && !fl;
      ra = r && (n > 0) && !fl;
      @(posedge clock);
      #1;
      m_ovf = (m_ovf && !ce) || (w && n == DEPTH && !fl);
      m_unf = (m_unf && !ce) || (r && n == 0 && !fl);
      if (fl) begin
         mq.delete();
         m_qv = 1'b0;
      end else begin
         m_qv = ra;
         if (ra) m_q = mq.pop_front();
         if (wa) mq.push_back(d);
      end
      $display("step w=%0d d=%h r=%0d fl=%0d ce=%0d -> level=%0d q=%h qv=%0d ovf=%0d unf=%0d",
               w, d, r, fl, ce, level, q, q_valid, overflow, underflow);
      wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; wr_data = '0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      mq.delete();
      m_q = '0; m_qv = 0; m_ovf = 0; m_unf = 0;
      $display("reset -> level=%0d empty=%0d q=%h", level, empty, q);
      check_all();
   endtask

   initial begin
      reset = 1'b1; flush = 0; wr_en = 0; rd_en = 0; clr_err = 0; wr_data = '0;
      m_q = '0; m_qv = 0; m_ovf = 0; m_unf = 0;
      repeat (2) @(posedge clock);
      do_reset();

      // Basic write then read of three words.
      step(1, 32'h11, 0, 0, 0);
      step(1, 32'h22, 0, 0, 0);
      step(1, 32'h33, 0, 0, 0);
      repeat (3) step(0, '0, 1, 0, 0);
      step(0, '0, 0, 0, 0);

      // Fill to full, then one overflowing write.
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1, $urandom, 0, 0, 0);
      step(1, 32'hDEAD_BEEF, 0, 0, 0);

      // Full with simultaneous read and write: read wins, write rejected.
      step(1, 32'h1234_5678, 1, 0, 0);

      // Drain to 5, then a long simultaneous stream across pointer wraps.
      while (mq.size() > 5) step(0, '0, 1, 0, 0);
      step(0, '0, 0, 0, 1);
      for (int i = 0; i < 300; i++) step(1, $urandom, 1, 0, 0);

      // Read on empty together with a write.
      while (mq.size() > 0) step(0, '0, 1, 0, 0);
      step(1, 32'hAA, 1, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 0, 0, 1);

      // Flush at level 10 with a concurrent write.
      for (int i = 0; i < 10; i++) step(1, $urandom, 0, 0, 0);
      step(1, 32'h5555, 0, 1, 0);
      step(0, '0, 0, 0, 0);

      // Reset while overflow is set.
      for (int i = 0; i <= DEPTH; i++) step(1, $urandom, 0, 0, 0);
      do_reset();

      // Randomized mix, biased so the level wanders across the whole range.
      for (int i = 0; i < 3000; i++) begin
         logic w, r, fl, ce;
         int   phase;
         phase = (i / 400) % 2;
         w  = ($urandom_range(0, 99) < (phase ? 70 : 30));
         r  = ($urandom_range(0, 99) < (phase ? 30 : 70));
         fl = ($urandom_range(0, 199) == 0);
         ce = ($urandom_range(0, 19) == 0);
         step(w, $urandom, r, fl, ce);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
